// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 7-segment bus (one-hot strobes + shared segments) back into packed BCD.
// Each digit is synchronised, stability-filtered, decoded and assembled into a frame.
module seg7_scan_reader #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    valid_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o
);

  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned BW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {SYNC, ACCUM, DONE} state_e;

  state_e                state_q, state_d;
  logic [6:0]            seg_s1_q, seg_s2_q, prev_seg_q;
  logic [NUM_DIGITS-1:0] sel_s1_q, sel_s2_q, prev_sel_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  captured_q, captured_d;
  logic [DW-1:0]         exp_q, exp_d;
  logic [BW-1:0]         slots_q, slots_d;
  logic                  bad_q, bad_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] sel_s;
  logic                  same_c, sel_nz_c, sel_multi_c, capture_c, dec_bad_c;
  logic [3:0]            dec_val_c;
  logic [DW-1:0]         dig_idx_c;

  assign seg_s = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
  assign sel_s = SEL_ACTIVE_LOW ? ~sel_s2_q : sel_s2_q;

  assign same_c      = (sel_s == prev_sel_q) && (seg_s == prev_seg_q);
  assign sel_nz_c    = |sel_s;
  assign sel_multi_c = |(sel_s & (sel_s - NUM_DIGITS'(1)));
  assign capture_c   = same_c && sel_nz_c && !sel_multi_c && !captured_q &&
                       (cnt_q == CW'(STABLE_CYCLES - 1));

  always_comb begin
    dig_idx_c = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_s[k]) dig_idx_c = DW'(k);
    end
  end

  // Lit-segment pattern (g..a) to BCD; anything else is flagged bad.
  always_comb begin
    dec_bad_c = 1'b0;
    case (seg_s)
      7'h3F:   dec_val_c = 4'd0;
      7'h06:   dec_val_c = 4'd1;
      7'h5B:   dec_val_c = 4'd2;
      7'h4F:   dec_val_c = 4'd3;
      7'h66:   dec_val_c = 4'd4;
      7'h6D:   dec_val_c = 4'd5;
      7'h7D:   dec_val_c = 4'd6;
      7'h07:   dec_val_c = 4'd7;
      7'h7F:   dec_val_c = 4'd8;
      7'h6F:   dec_val_c = 4'd9;
      default: begin
        dec_val_c = 4'hF;
        dec_bad_c = 1'b1;
      end
    endcase
  end

  // Stability counter saturates at the capture threshold; captured blocks repeats until S moves.
  always_comb begin
    cnt_d      = cnt_q;
    captured_d = captured_q;
    if (!same_c || !sel_nz_c) cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYCLES - 1)) cnt_d = cnt_q + CW'(1);
    if (!same_c) captured_d = 1'b0;
    else if (capture_c) captured_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    slots_d = slots_q;
    bad_d   = bad_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = 2'b00;
    case (state_q)
      SYNC: begin
        if (capture_c && dig_idx_c == '0) begin
          slots_d[3:0] = dec_val_c;
          exp_d        = DW'(1);
          bad_d        = dec_bad_c;
          err_d        = dec_bad_c;
          code_d       = dec_bad_c ? 2'b01 : 2'b00;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        if (capture_c) begin
          if (dig_idx_c == exp_q) begin
            slots_d[{dig_idx_c, 2'b00} +: 4] = dec_val_c;
            exp_d  = exp_q + DW'(1);
            bad_d  = bad_q | dec_bad_c;
            err_d  = dec_bad_c;
            code_d = dec_bad_c ? 2'b01 : 2'b00;
            // Publish on the last digit so valid_o lands one cycle after its capture.
            if (dig_idx_c == DW'(NUM_DIGITS - 1)) begin
              state_d = DONE;
              valid_d = !(bad_q | dec_bad_c);
              if (!(bad_q | dec_bad_c)) bcd_d = slots_d;
            end
          end else if (dig_idx_c == '0) begin
            slots_d[3:0] = dec_val_c;
            exp_d        = DW'(1);
            bad_d        = dec_bad_c;
            err_d        = 1'b1;
            code_d       = 2'b10;
          end else begin
            bad_d   = 1'b0;
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = SYNC;
          end
        end
      end
      DONE: begin
        bad_d   = 1'b0;
        state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase
    // A new multi-bit select overrides everything else and forces a resync.
    if (sel_multi_c && sel_s != prev_sel_q) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      bad_d   = 1'b0;
      state_d = SYNC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      prev_seg_q <= '0;
      prev_sel_q <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      state_q    <= SYNC;
      exp_q      <= '0;
      slots_q    <= '0;
      bad_q      <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      seg_s1_q   <= seg_i;
      seg_s2_q   <= seg_s1_q;
      sel_s1_q   <= dig_sel_i;
      sel_s2_q   <= sel_s1_q;
      prev_seg_q <= seg_s;
      prev_sel_q <= sel_s;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      slots_q    <= slots_d;
      bad_q      <= bad_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign bcd_o      = bcd_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: 4 digits, STABLE_CYCLES=4, active-high lines.
module tb_seg7_scan_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [6:0]  seg_i = '0;
  logic [3:0]  dig_sel_i = '0;
  logic [15:0] bcd_o;
  logic        valid_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [1:0] last_code = 2'b00;
  int v0, e0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scan_reader #(
    .NUM_DIGITS(4), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .seg_i(seg_i), .dig_sel_i(dig_sel_i),
    .bcd_o(bcd_o), .valid_o(valid_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (valid_o) valid_cnt = valid_cnt + 1;
    if (err_o) begin
      err_cnt   = err_cnt + 1;
      last_code = err_code_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int d, input logic [6:0] s, input int n);
    dig_sel_i = 4'(1 << d);
    seg_i     = s;
    repeat (n) @(posedge clk_i);
  endtask

  task automatic blank(input int n);
    dig_sel_i = '0;
    seg_i     = '0;
    repeat (n) @(posedge clk_i);
  endtask

  task automatic frame(input int d0, input int d1, input int d2, input int d3, input int gap);
    strobe(0, seg_tab[d0], 8); if (gap > 0) blank(gap);
    strobe(1, seg_tab[d1], 8); if (gap > 0) blank(gap);
    strobe(2, seg_tab[d2], 8); if (gap > 0) blank(gap);
    strobe(3, seg_tab[d3], 8);
    blank(6);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_bcd", 32'(bcd_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_code", 32'(err_code_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    blank(4);

    // Single clean frame 1,9,8,5
    snap();
    frame(1, 9, 8, 5, 0);
    chk("f1_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    chk("f1_bcd", 32'(bcd_o), 32'h5891);
    chk("f1_no_err", 32'(err_cnt - e0), 32'd0);

    // Three frames with blanking gaps
    snap();
    repeat (3) frame(1, 9, 8, 5, 2);
    chk("f3_valid_pulses", 32'(valid_cnt - v0), 32'd3);
    chk("f3_bcd", 32'(bcd_o), 32'h5891);
    chk("f3_no_err", 32'(err_cnt - e0), 32'd0);

    // Digit 2 too short to capture, digit 3 out of sequence
    snap();
    strobe(0, seg_tab[2], 8);
    strobe(1, seg_tab[4], 8);
    strobe(2, seg_tab[6], 3);
    strobe(3, seg_tab[7], 8);
    blank(6);
    chk("short_err_count", 32'(err_cnt - e0), 32'd1);
    chk("short_err_code", 32'(last_code), 32'h2);
    chk("short_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("short_bcd_hold", 32'(bcd_o), 32'h5891);

    // Invalid pattern on digit 1, then a clean frame
    snap();
    strobe(0, seg_tab[0], 8);
    strobe(1, 7'h77, 8);
    strobe(2, seg_tab[2], 8);
    strobe(3, seg_tab[3], 8);
    blank(6);
    chk("bad_err_count", 32'(err_cnt - e0), 32'd1);
    chk("bad_err_code", 32'(last_code), 32'h1);
    chk("bad_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("bad_bcd_hold", 32'(bcd_o), 32'h5891);
    snap();
    frame(4, 3, 2, 1, 0);
    chk("clean_valid", 32'(valid_cnt - v0), 32'd1);
    chk("clean_bcd", 32'(bcd_o), 32'h1234);
    chk("clean_no_err", 32'(err_cnt - e0), 32'd0);

    // Non-one-hot select mid-frame forces resync
    snap();
    strobe(0, seg_tab[6], 8);
    strobe(1, seg_tab[7], 8);
    dig_sel_i = 4'b0110;
    seg_i     = seg_tab[8];
    repeat (6) @(posedge clk_i);
    frame(6, 7, 0, 9, 0);
    chk("multi_err_count", 32'(err_cnt - e0), 32'd1);
    chk("multi_err_code", 32'(last_code), 32'h3);
    chk("multi_valid", 32'(valid_cnt - v0), 32'd1);
    chk("multi_bcd", 32'(bcd_o), 32'h9076);

    // Asynchronous reset mid-frame, partial resume, then a full frame
    snap();
    strobe(0, seg_tab[5], 8);
    strobe(1, seg_tab[5], 8);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd_o), 32'h0);
    chk("arst_valid", 32'(valid_o), 32'h0);
    #9 rst_ni = 1'b1;
    @(posedge clk_i);
    strobe(2, seg_tab[5], 8);
    strobe(3, seg_tab[5], 8);
    blank(6);
    chk("resume_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("resume_bcd_zero", 32'(bcd_o), 32'h0);
    frame(2, 4, 6, 8, 0);
    chk("after_rst_valid", 32'(valid_cnt - v0), 32'd1);
    chk("after_rst_bcd", 32'(bcd_o), 32'h8642);
    chk("after_rst_no_err", 32'(err_cnt - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
